sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. It is the next-generation replacement for the fixed 16-bit, 8-entry buffer on the accelerator datapath. It adds configurable width and depth, use of all DEPTH entries, simultaneous read and write, an occupancy count, almost-full/almost-empty thresholds and a read-valid strobe. It sits between producer and consumer stages, such as a weight/activation loader feeding a PE row.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem.sv | 40 ++++
 rtl/sync_fifo_param.sv | 111 +++++++++++
 tb/tb_sync_fifo_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, pointer-width helper and status bundle
// for the parametrised FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_W = 16;
    localparam int FIFO_DEPTH  = 8;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W register array, one write port and a
// registered read port that holds its value when no read is accepted.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage is never reset; only the output register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count and thresholds.
// Define FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    localparam int CNT_W   = ptr_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wn,
    input  logic              rn,
    input  logic [DATA_W-1:0] DATAIN,
    output logic [DATA_W-1:0] DATAOUT,
    output logic              rvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = CNT_W - 1;

    logic [CNT_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_rptr;
    logic             r_rvalid;
    logic [CNT_W-1:0] w_count;
    logic             w_wr_ok;
    logic             w_rd_ok;
    fifo_status_t     w_status;

    // Extra pointer bit makes the modular difference span 0..DEPTH.
    assign w_count = r_wptr - r_rptr;

    assign w_status.full         = (w_count == CNT_W'(DEPTH));
    assign w_status.empty        = (w_count == '0);
    assign w_status.almost_full  = (w_count >= CNT_W'(AF_LEVEL));
    assign w_status.almost_empty = (w_count <= CNT_W'(AE_LEVEL));

    assign w_wr_ok = wn & ~w_status.full & reset;
    assign w_rd_ok = rn & ~w_status.empty & reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + CNT_W'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + CNT_W'(1);
            end
            r_rvalid <= w_rd_ok;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (DATAIN),
        .i_re    (w_rd_ok),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (DATAOUT)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wn & w_status.full) begin
                r_overflow <= 1'b1;
            end
            if (rn & w_status.empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign rvalid       = r_rvalid;
    assign count        = w_count;
    assign full         = w_status.full;
    assign empty        = w_status.empty;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for the default FIFO and a
// 32x16 instance with thresholds 12/3.
`timescale 1ns/1ps
module tb_sync_fifo_param;

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int D  = 8;
    localparam int D2 = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wn = 1'b0;
    logic        rn = 1'b0;
    logic [15:0] DATAIN = '0;
    logic [15:0] DATAOUT;
    logic        rvalid, full, empty, almost_full, almost_empty;
    logic [3:0]  count;
    logic        overflow, underflow;

    logic        wn2 = 1'b0;
    logic        rn2 = 1'b0;
    logic [31:0] din2 = '0;
    logic [31:0] dout2;
    logic        rvalid2, full2, empty2, af2, ae2;
    logic [4:0]  count2;
    logic        ovf2, udf2;

    int total = 0;
    int bad   = 0;

    logic [15:0] mq[$];
    logic [15:0] eq[$];
    logic [31:0] mq2[$];
    logic [31:0] eq2[$];
    bit pend  = 1'b0;
    bit pend2 = 1'b0;
    bit ovf_m = 1'b0;
    bit udf_m = 1'b0;
    int rv_seen = 0;

    always #5 clock = ~clock;

    sync_fifo_param u_dut (
        .clock        (clock),
        .reset        (reset),
        .wn           (wn),
        .rn           (rn),
        .DATAIN       (DATAIN),
        .DATAOUT      (DATAOUT),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    sync_fifo_param #(
        .DATA_W   (32),
        .DEPTH    (16),
        .AF_LEVEL (12),
        .AE_LEVEL (3)
    ) u_dut2 (
        .clock        (clock),
        .reset        (reset),
        .wn           (wn2),
        .rn           (rn2),
        .DATAIN       (din2),
        .DATAOUT      (dout2),
        .rvalid       (rvalid2),
        .full         (full2),
        .empty        (empty2),
        .almost_full  (af2),
        .almost_empty (ae2),
        .count        (count2),
        .overflow     (ovf2),
        .underflow    (udf2)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitors: pop the expected word whenever a read result appears.
    always @(negedge clock) begin
        chk("rvalid", {63'd0, rvalid}, {63'd0, pend});
        if (rvalid) begin
            rv_seen++;
            if (eq.size() > 0) chk("dataout", {48'd0, DATAOUT}, {48'd0, eq.pop_front()});
        end
    end

    always @(negedge clock) begin
        chk("rvalid2", {63'd0, rvalid2}, {63'd0, pend2});
        if (rvalid2 && eq2.size() > 0) begin
            chk("dataout2", {32'd0, dout2}, {32'd0, eq2.pop_front()});
        end
    end

    task automatic step(bit w, bit r, logic [15:0] d);
        bit wok, rok;
        wn = w;
        rn = r;
        DATAIN = d;
        @(posedge clock);
        wok = w && mq.size() < D;
        rok = r && mq.size() > 0;
        if (ERR_EN && w && mq.size() == D) ovf_m = 1'b1;
        if (ERR_EN && r && mq.size() == 0) udf_m = 1'b1;
        if (rok) eq.push_back(mq.pop_front());
        if (wok) mq.push_back(d);
        pend = rok;
        @(negedge clock);
        wn = 1'b0;
        rn = 1'b0;
        DATAIN = 16'hxxxx;
        chk("count", {60'd0, count}, 64'(mq.size()));
        chk("full", {63'd0, full}, {63'd0, mq.size() == D});
        chk("empty", {63'd0, empty}, {63'd0, mq.size() == 0});
        chk("almost_full", {63'd0, almost_full}, {63'd0, mq.size() >= 6});
        chk("almost_empty", {63'd0, almost_empty}, {63'd0, mq.size() <= 1});
        chk("overflow", {63'd0, overflow}, {63'd0, ovf_m});
        chk("underflow", {63'd0, underflow}, {63'd0, udf_m});
    endtask

    task automatic step2(bit w, bit r, logic [31:0] d);
        bit wok, rok;
        wn2 = w;
        rn2 = r;
        din2 = d;
        @(posedge clock);
        wok = w && mq2.size() < D2;
        rok = r && mq2.size() > 0;
        if (rok) eq2.push_back(mq2.pop_front());
        if (wok) mq2.push_back(d);
        pend2 = rok;
        @(negedge clock);
        wn2 = 1'b0;
        rn2 = 1'b0;
        chk("count2", {59'd0, count2}, 64'(mq2.size()));
        chk("full2", {63'd0, full2}, {63'd0, mq2.size() == D2});
        chk("empty2", {63'd0, empty2}, {63'd0, mq2.size() == 0});
        chk("af2", {63'd0, af2}, {63'd0, mq2.size() >= 12});
        chk("ae2", {63'd0, ae2}, {63'd0, mq2.size() <= 3});
    endtask

    task automatic do_reset(bit w, bit r);
        reset = 1'b0;
        wn = w;
        rn = r;
        DATAIN = 16'h5555;
        @(posedge clock);
        mq.delete();
        pend = 1'b0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        wn = 1'b0;
        rn = 1'b0;
        chk("rst_count", {60'd0, count}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_af", {63'd0, almost_full}, 64'd0);
        chk("rst_ae", {63'd0, almost_empty}, 64'd1);
        chk("rst_dout", {48'd0, DATAOUT}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_udf", {63'd0, underflow}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int af_first;
        int ae_drop;
        do_reset(1'b0, 1'b0);

        af_first = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 16'(i));
            if (almost_full && af_first == 0) af_first = int'(count);
        end
        chk("af_first_level", 64'(af_first), 64'd6);
        chk("full_at_8", {60'd0, count}, 64'd8);
        step(1'b1, 1'b0, 16'h0009);

        rv_seen = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'hxxxx);
        step(1'b0, 1'b0, 16'hxxxx);
        chk("rvalid_pulses", 64'(rv_seen), 64'd8);
        step(1'b0, 1'b1, 16'hxxxx);
        chk("dout_hold", {48'd0, DATAOUT}, 64'h0008);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0011 + 16'(i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'hxxxx);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0021 + 16'(i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'hxxxx);
        step(1'b0, 1'b0, 16'hxxxx);
        chk("wrap_count0", {60'd0, count}, 64'd0);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0031 + 16'(i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 16'h0040 + 16'(i));
        chk("wr_rd_count3", {60'd0, count}, 64'd3);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0050 + 16'(i));
        step(1'b1, 1'b1, 16'hDEAD);
        chk("wr_rd_at_full", {60'd0, count}, 64'd7);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'hxxxx);
        step(1'b0, 1'b0, 16'hxxxx);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0060 + 16'(i));
        chk("pre_reset_count5", {60'd0, count}, 64'd5);
        do_reset(1'b1, 1'b1);
        step(1'b1, 1'b0, 16'hBEEF);
        step(1'b0, 1'b1, 16'hxxxx);
        chk("beef", {48'd0, DATAOUT}, 64'hBEEF);
        step(1'b0, 1'b0, 16'hxxxx);

        af_first = 0;
        ae_drop = 0;
        for (int i = 1; i <= 16; i++) begin
            step2(1'b1, 1'b0, 32'hA000_0000 + 32'(i));
            if (af2 && af_first == 0) af_first = int'(count2);
            if (!ae2 && ae_drop == 0) ae_drop = int'(count2);
        end
        chk("sweep_af_first", 64'(af_first), 64'd12);
        chk("sweep_ae_drop", 64'(ae_drop), 64'd4);
        chk("sweep_full16", {63'd0, full2}, 64'd1);
        step2(1'b1, 1'b0, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) step2(1'b0, 1'b1, 32'h0);
        step2(1'b0, 1'b0, 32'h0);

        chk("pending_out", 64'(eq.size() + eq2.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
